reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH_BIT, default 5, giving log2 of the entry count (32 entries).
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, the reset; asynchronous, active-high.
REQ-004 SHALL have port rdy_in, input, 1; when low, the block holds all state and drives every pulse output to 0.
REQ-005 SHALL have issue ports, all inputs:
- issue_valid, 1
- issue_ready, 1: value already known
- issue_value, 32
- issue_rd, 5
- issue_type, ROB_TYPE
- issue_addr, 32: instruction pc
- issue_jp_addr, 32: predicted next pc
REQ-006 SHALL have outputs rob_tail, 5 (id the next issue receives) and rob_full, 1.
REQ-007 SHALL have writeback inputs:
- alu_wb_valid, 1; alu_wb_id, 5; alu_wb_value, 32 (for branches, the resolved next pc)
- lsb_wb_valid, 1; lsb_wb_id, 5; lsb_wb_value, 32
REQ-008 SHALL have commit outputs:
- commit_valid, 1
- commit_rd, 5
- commit_value, 32
- commit_id, 5
- st_commit, 1: store may write memory
REQ-009 SHALL have flush outputs flush, 1 (pulse) and flush_addr, 32.
REQ-010 SHALL have operand query ports: inputs qry_id1 and qry_id2, 5 each; combinational outputs qry_rdy1 and qry_rdy2 (1 each) and qry_val1 and qry_val2 (32 each).

Function
REQ-011 Each entry SHALL hold busy, ready, type, rd, value, addr and jp_addr; head, tail and count SHALL wrap modulo 2^ROB_WIDTH_BIT.
REQ-012 rob_full SHALL be asserted combinationally when count >= DEPTH-1, leaving one slot for the issuing stage's registered latency.
REQ-013 On issue_valid, the entry at tail SHALL be written with busy=1 and ready=issue_ready; tail SHALL then increment.
REQ-014 A writeback to a busy entry SHALL set ready=1 and store the value; a writeback to a non-busy entry SHALL be ignored.
REQ-015 If both writeback ports target the same id in one cycle, the ALU port SHALL win.
REQ-016 A writeback to the head entry SHALL become visible to commit on the following cycle, not the same cycle.
REQ-017 When the head entry is busy and ready, exactly one commit per cycle SHALL occur.
REQ-018 Commit outputs SHALL be registered one-cycle pulses:
- TypeRd and TypeJp: commit_valid=1, with rd and value.
- TypeSt: st_commit=1, commit_valid=0.
- TypeBr: neither.
REQ-019 A TypeBr commit whose value differs from jp_addr SHALL pulse flush with flush_addr=value, clear every busy bit, and reset head, tail and count to 0.
REQ-020 On a flush, an issue or writeback arriving in the same cycle SHALL be discarded.
REQ-021 A simultaneous issue and commit SHALL leave count unchanged.
REQ-022 A query SHALL return rdy=1 and the entry value when the entry is busy and ready; otherwise rdy=0 and val=0.

Reset
REQ-023 On rst_in, asynchronously: head, tail and count = 0; all busy bits = 0; every output = 0 (rob_full = 0).
REQ-024 Assertion of rst_in mid-operation SHALL discard all entries, with no commit pulse emitted afterwards.

Structure
REQ-025 ROB_WIDTH_BIT, ROB_TYPE and TypeRd/TypeSt/TypeBr/TypeJp SHALL reside in the shared const.v header.
REQ-026 The block SHALL be a single flat module with no sub-module; storage SHALL be register arrays indexed by id.

Verification
REQ-027 Issue TypeRd (rd=5, issue_ready=0) at id 0; ALU writeback id 0 with value 0x1234 -> two cycles later, commit_valid=1, commit_rd=5, commit_value=0x1234.
REQ-028 Issue 31 entries without writebacks -> rob_full=1 after the 31st issue; commit one entry -> rob_full=0 the next cycle.
REQ-029 TypeBr with jp_addr=0x100; writeback value 0x200 -> at commit, flush=1, flush_addr=0x200, rob_tail=0 the next cycle, and an issue in the same cycle is dropped.
REQ-030 Simultaneous ALU and LSB writeback to id 3 with values 7 and 9 -> entry 3 value = 7.
REQ-031 Fill until tail wraps 31->0, committing in order -> commit_id sequence 30, 31, 0, 1.
REQ-032 Assert rst_in asynchronously mid-stream with a ready head -> all outputs 0 immediately; no commit after release.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry type encoding for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_BIT = 5;
  localparam int ROB_TYPE_W    = 2;

  typedef enum logic [ROB_TYPE_W-1:0] {
    TypeRd = 2'd0,
    TypeSt = 2'd1,
    TypeBr = 2'd2,
    TypeJp = 2'd3
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular entry array with issue, dual writeback,
// single-entry commit per cycle, branch-mispredict flush and operand queries.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = reorder_buffer_pkg::ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,

  input  logic                     issue_valid,
  input  logic                     issue_ready,
  input  logic [31:0]              issue_value,
  input  logic [4:0]               issue_rd,
  input  logic [1:0]               issue_type,
  input  logic [31:0]              issue_addr,
  input  logic [31:0]              issue_jp_addr,

  output logic [ROB_WIDTH_BIT-1:0] rob_tail,
  output logic                     rob_full,

  input  logic                     alu_wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] alu_wb_id,
  input  logic [31:0]              alu_wb_value,
  input  logic                     lsb_wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_wb_id,
  input  logic [31:0]              lsb_wb_value,

  output logic                     commit_valid,
  output logic [4:0]               commit_rd,
  output logic [31:0]              commit_value,
  output logic [ROB_WIDTH_BIT-1:0] commit_id,
  output logic                     st_commit,

  output logic                     flush,
  output logic [31:0]              flush_addr,

  input  logic [ROB_WIDTH_BIT-1:0] qry_id1,
  input  logic [ROB_WIDTH_BIT-1:0] qry_id2,
  output logic                     qry_rdy1,
  output logic                     qry_rdy2,
  output logic [31:0]              qry_val1,
  output logic [31:0]              qry_val2
);

  import reorder_buffer_pkg::*;

  localparam int DEPTH = 1 << ROB_WIDTH_BIT;

  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;

  localparam rob_id_t ID_ONE   = rob_id_t'(1);
  localparam rob_id_t CNT_FULL = rob_id_t'(DEPTH - 1);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] ready_q;
  rob_type_e        type_q    [DEPTH];
  logic [4:0]       rd_q      [DEPTH];
  logic [31:0]      value_q   [DEPTH];
  logic [31:0]      addr_q    [DEPTH];
  logic [31:0]      jp_addr_q [DEPTH];

  rob_id_t head_q;
  rob_id_t tail_q;
  rob_id_t count_q;

  logic commit_valid_q;
  logic st_commit_q;
  logic flush_q;

  logic head_commit;
  logic head_mispredict;
  logic do_issue;
  logic alu_wb;
  logic lsb_wb;

  // Commit decisions read only registered state, so a writeback to the head
  // reaches commit one cycle after it lands.
  assign head_commit     = rdy_in & busy_q[head_q] & ready_q[head_q];
  assign head_mispredict = head_commit && (type_q[head_q] == TypeBr) &&
                           (value_q[head_q] != jp_addr_q[head_q]);

  assign do_issue = rdy_in & issue_valid  & ~head_mispredict;
  assign alu_wb   = rdy_in & alu_wb_valid & busy_q[alu_wb_id] & ~head_mispredict;
  assign lsb_wb   = rdy_in & lsb_wb_valid & busy_q[lsb_wb_id] & ~head_mispredict;

  // NOTE: all sequential state uses non-blocking assignments so every read in
  // this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      st_commit_q    <= 1'b0;
      flush_q        <= 1'b0;
      commit_rd      <= '0;
      commit_value   <= '0;
      commit_id      <= '0;
      flush_addr     <= '0;
    end else begin
      commit_valid_q <= 1'b0;
      st_commit_q    <= 1'b0;
      flush_q        <= 1'b0;

      if (head_mispredict) begin
        busy_q     <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        flush_q    <= 1'b1;
        flush_addr <= value_q[head_q];
      end else begin
        if (head_commit) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + ID_ONE;
          commit_id      <= head_q;
          commit_rd      <= rd_q[head_q];
          commit_value   <= value_q[head_q];
          commit_valid_q <= (type_q[head_q] == TypeRd) || (type_q[head_q] == TypeJp);
          st_commit_q    <= (type_q[head_q] == TypeSt);
        end

        // Later assignment wins: ALU takes priority over LSB on the same id.
        if (lsb_wb) ready_q[lsb_wb_id] <= 1'b1;
        if (alu_wb) ready_q[alu_wb_id] <= 1'b1;

        if (do_issue) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= issue_ready;
          tail_q          <= tail_q + ID_ONE;
        end

        unique case ({do_issue, head_commit})
          2'b10:   count_q <= count_q + ID_ONE;
          2'b01:   count_q <= count_q - ID_ONE;
          default: ;
        endcase
      end
    end
  end

  // NOTE: entry payload is not reset; busy_q alone decides whether a slot holds
  // anything meaningful, which keeps the arrays as plain register storage.
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      type_q[tail_q]    <= rob_type_e'(issue_type);
      rd_q[tail_q]      <= issue_rd;
      value_q[tail_q]   <= issue_value;
      addr_q[tail_q]    <= issue_addr;
      jp_addr_q[tail_q] <= issue_jp_addr;
    end
    if (lsb_wb) value_q[lsb_wb_id] <= lsb_wb_value;
    if (alu_wb) value_q[alu_wb_id] <= alu_wb_value;
  end

  // Instruction pc is kept per entry for trap/debug reporting; commit does not consume it yet.
  logic unused_pc;
  assign unused_pc = ^addr_q[head_q];

  assign rob_tail     = tail_q;
  assign rob_full     = (count_q >= CNT_FULL);
  assign commit_valid = commit_valid_q & rdy_in;
  assign st_commit    = st_commit_q & rdy_in;
  assign flush        = flush_q & rdy_in;

  assign qry_rdy1 = busy_q[qry_id1] & ready_q[qry_id1];
  assign qry_rdy2 = busy_q[qry_id2] & ready_q[qry_id2];
  assign qry_val1 = qry_rdy1 ? value_q[qry_id1] : '0;
  assign qry_val2 = qry_rdy2 ? value_q[qry_id2] : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: commit path, full, flush,
// writeback priority, pointer wrap and asynchronous reset.
module tb_reorder_buffer;

  import reorder_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_value, issue_addr, issue_jp_addr;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_type;
  logic [4:0]  rob_tail;
  logic        rob_full;
  logic        alu_wb_valid, lsb_wb_valid;
  logic [4:0]  alu_wb_id, lsb_wb_id;
  logic [31:0] alu_wb_value, lsb_wb_value;
  logic        commit_valid, st_commit, flush;
  logic [4:0]  commit_rd, commit_id;
  logic [31:0] commit_value, flush_addr;
  logic [4:0]  qry_id1, qry_id2;
  logic        qry_rdy1, qry_rdy2;
  logic [31:0] qry_val1, qry_val2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_value(issue_value),
    .issue_rd(issue_rd), .issue_type(issue_type), .issue_addr(issue_addr),
    .issue_jp_addr(issue_jp_addr),
    .rob_tail(rob_tail), .rob_full(rob_full),
    .alu_wb_valid(alu_wb_valid), .alu_wb_id(alu_wb_id), .alu_wb_value(alu_wb_value),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_id(lsb_wb_id), .lsb_wb_value(lsb_wb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_id(commit_id), .st_commit(st_commit),
    .flush(flush), .flush_addr(flush_addr),
    .qry_id1(qry_id1), .qry_id2(qry_id2), .qry_rdy1(qry_rdy1), .qry_rdy2(qry_rdy2),
    .qry_val1(qry_val1), .qry_val2(qry_val2)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_ready = 1'b0; issue_value = '0; issue_rd = '0;
    issue_type = TypeRd; issue_addr = '0; issue_jp_addr = '0;
    alu_wb_valid = 1'b0; alu_wb_id = '0; alu_wb_value = '0;
    lsb_wb_valid = 1'b0; lsb_wb_id = '0; lsb_wb_value = '0;
  endtask

  task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                             input logic [31:0] val, input logic [31:0] jp);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_ready = rdy;
    issue_value = val; issue_jp_addr = jp; issue_addr = 32'h1000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rdy_in = 1'b1; qry_id1 = '0; qry_id2 = '0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_commit_valid: got %0h want 0", commit_valid); end
    tests_run++; if (st_commit !== 1'b0) begin tests_failed++; $display("FAIL reset_st_commit: got %0h want 0", st_commit); end
    tests_run++; if (flush !== 1'b0 || flush_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_flush: got %0h/%0h want 0/0", flush, flush_addr); end
    tests_run++; if (rob_tail !== 5'd0 || rob_full !== 1'b0) begin tests_failed++; $display("FAIL reset_tail_full: got %0d/%0h want 0/0", rob_tail, rob_full); end
    tests_run++; if (commit_rd !== 5'd0 || commit_value !== 32'h0 || commit_id !== 5'd0) begin tests_failed++; $display("FAIL reset_commit_data: got rd=%0d val=%0h id=%0d want 0", commit_rd, commit_value, commit_id); end
    tests_run++; if (qry_rdy1 !== 1'b0 || qry_val1 !== 32'h0) begin tests_failed++; $display("FAIL reset_query: got %0h/%0h want 0/0", qry_rdy1, qry_val1); end
  endtask

  task automatic test_commit_rd();
    do_reset();
    drive_issue(TypeRd, 5'd5, 1'b0, 32'h0, 32'h0);
    tick();
    clear_inputs();
    qry_id1 = 5'd0;
    #1;
    tests_run++; if (qry_rdy1 !== 1'b0 || qry_val1 !== 32'h0) begin tests_failed++; $display("FAIL query_not_ready: got %0h/%0h want 0/0", qry_rdy1, qry_val1); end
    alu_wb_valid = 1'b1; alu_wb_id = 5'd0; alu_wb_value = 32'h1234;
    tick();
    clear_inputs();
    tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL wb_head_same_cycle: got %0h want 0", commit_valid); end
    tests_run++; if (qry_rdy1 !== 1'b1 || qry_val1 !== 32'h1234) begin tests_failed++; $display("FAIL query_ready: got %0h/%0h want 1/1234", qry_rdy1, qry_val1); end
    tick();
    tests_run++; if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_value !== 32'h1234 || commit_id !== 5'd0)
      begin tests_failed++; $display("FAIL rd_commit: got v=%0h rd=%0d val=%0h id=%0d want 1/5/1234/0", commit_valid, commit_rd, commit_value, commit_id); end
    tick();
    tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL commit_pulse_width: got %0h want 0", commit_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      drive_issue(TypeRd, 5'(i), 1'b0, 32'(i), 32'h0);
      tick();
      if (i == 29) begin
        tests_run++; if (rob_full !== 1'b0) begin tests_failed++; $display("FAIL full_at_30: got %0h want 0", rob_full); end
      end
    end
    clear_inputs();
    tests_run++; if (rob_full !== 1'b1 || rob_tail !== 5'd31) begin tests_failed++; $display("FAIL full_at_31: got %0h tail=%0d want 1/31", rob_full, rob_tail); end
    alu_wb_valid = 1'b1; alu_wb_id = 5'd0; alu_wb_value = 32'hAA;
    tick();
    clear_inputs();
    tests_run++; if (rob_full !== 1'b1) begin tests_failed++; $display("FAIL full_before_commit: got %0h want 1", rob_full); end
    tick();
    tests_run++; if (rob_full !== 1'b0 || commit_valid !== 1'b1 || commit_id !== 5'd0)
      begin tests_failed++; $display("FAIL full_after_commit: got full=%0h v=%0h id=%0d want 0/1/0", rob_full, commit_valid, commit_id); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_issue(TypeBr, 5'd0, 1'b0, 32'h0, 32'h100);
    tick();
    drive_issue(TypeRd, 5'd3, 1'b1, 32'h55, 32'h0);
    tick();
    clear_inputs();
    qry_id1 = 5'd1; qry_id2 = 5'd0;
    #1;
    tests_run++; if (qry_rdy1 !== 1'b1 || qry_val1 !== 32'h55 || rob_tail !== 5'd2)
      begin tests_failed++; $display("FAIL pre_flush_state: got %0h/%0h tail=%0d want 1/55/2", qry_rdy1, qry_val1, rob_tail); end
    alu_wb_valid = 1'b1; alu_wb_id = 5'd0; alu_wb_value = 32'h200;
    tick();
    clear_inputs();
    drive_issue(TypeRd, 5'd4, 1'b1, 32'h66, 32'h0);
    tick();
    clear_inputs();
    tests_run++; if (flush !== 1'b1 || flush_addr !== 32'h200) begin tests_failed++; $display("FAIL flush_pulse: got %0h/%0h want 1/200", flush, flush_addr); end
    tests_run++; if (rob_tail !== 5'd0 || commit_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_tail: got tail=%0d v=%0h want 0/0", rob_tail, commit_valid); end
    tests_run++; if (qry_rdy1 !== 1'b0 || qry_rdy2 !== 1'b0) begin tests_failed++; $display("FAIL flush_clears: got %0h/%0h want 0/0", qry_rdy1, qry_rdy2); end
    tick();
    tests_run++; if (flush !== 1'b0 || rob_tail !== 5'd0 || commit_valid !== 1'b0)
      begin tests_failed++; $display("FAIL flush_after: got f=%0h tail=%0d v=%0h want 0/0/0", flush, rob_tail, commit_valid); end
    // Correctly predicted branch retires silently.
    drive_issue(TypeBr, 5'd0, 1'b1, 32'h300, 32'h300);
    tick();
    clear_inputs();
    tick();
    tests_run++; if (flush !== 1'b0 || commit_valid !== 1'b0 || st_commit !== 1'b0 || commit_id !== 5'd0)
      begin tests_failed++; $display("FAIL br_correct: got f=%0h v=%0h st=%0h id=%0d want 0/0/0/0", flush, commit_valid, st_commit, commit_id); end
  endtask

  task automatic test_store_jump();
    do_reset();
    drive_issue(TypeSt, 5'd0, 1'b1, 32'h0, 32'h0);
    tick();
    drive_issue(TypeJp, 5'd7, 1'b1, 32'h44, 32'h44);
    tick();
    clear_inputs();
    tests_run++; if (st_commit !== 1'b1 || commit_valid !== 1'b0) begin tests_failed++; $display("FAIL st_commit: got st=%0h v=%0h want 1/0", st_commit, commit_valid); end
    tick();
    tests_run++; if (commit_valid !== 1'b1 || st_commit !== 1'b0 || commit_rd !== 5'd7 || commit_value !== 32'h44 || commit_id !== 5'd1)
      begin tests_failed++; $display("FAIL jp_commit: got v=%0h st=%0h rd=%0d val=%0h id=%0d want 1/0/7/44/1", commit_valid, st_commit, commit_rd, commit_value, commit_id); end
    alu_wb_valid = 1'b1; alu_wb_id = 5'd10; alu_wb_value = 32'h99;
    tick();
    clear_inputs();
    qry_id2 = 5'd10;
    #1;
    tests_run++; if (qry_rdy2 !== 1'b0 || qry_val2 !== 32'h0) begin tests_failed++; $display("FAIL wb_not_busy: got %0h/%0h want 0/0", qry_rdy2, qry_val2); end
    rdy_in = 1'b0;
    drive_issue(TypeRd, 5'd1, 1'b1, 32'h11, 32'h0);
    tick();
    clear_inputs();
    tests_run++; if (rob_tail !== 5'd2 || commit_valid !== 1'b0) begin tests_failed++; $display("FAIL rdy_hold: got tail=%0d v=%0h want 2/0", rob_tail, commit_valid); end
    rdy_in = 1'b1;
  endtask

  task automatic test_wb_priority();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_issue(TypeRd, 5'(i), 1'b0, 32'h0, 32'h0);
      tick();
    end
    clear_inputs();
    alu_wb_valid = 1'b1; alu_wb_id = 5'd3; alu_wb_value = 32'd7;
    lsb_wb_valid = 1'b1; lsb_wb_id = 5'd3; lsb_wb_value = 32'd9;
    tick();
    clear_inputs();
    qry_id1 = 5'd3; qry_id2 = 5'd0;
    #1;
    tests_run++; if (qry_rdy1 !== 1'b1 || qry_val1 !== 32'd7) begin tests_failed++; $display("FAIL wb_priority: got %0h/%0d want 1/7", qry_rdy1, qry_val1); end
    tests_run++; if (qry_rdy2 !== 1'b0 || commit_valid !== 1'b0) begin tests_failed++; $display("FAIL wb_head_pending: got %0h/%0h want 0/0", qry_rdy2, commit_valid); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [4:0]  cid_q [$];
    logic [31:0] cval_q [$];
    logic [4:0]  exp_id [4];
    exp_id[0] = 5'd30; exp_id[1] = 5'd31; exp_id[2] = 5'd0; exp_id[3] = 5'd1;
    do_reset();
    for (int i = 0; i < 35; i++) begin
      if (i < 34) drive_issue(TypeRd, 5'd1, 1'b1, 32'(i), 32'h0);
      else clear_inputs();
      tick();
      if (commit_valid === 1'b1) begin
        cid_q.push_back(commit_id);
        cval_q.push_back(commit_value);
      end
    end
    tests_run++; if (cid_q.size() !== 34) begin tests_failed++; $display("FAIL wrap_count: got %0d want 34", cid_q.size()); end
    tests_run++; if (rob_tail !== 5'd2 || rob_full !== 1'b0) begin tests_failed++; $display("FAIL wrap_tail: got %0d/%0h want 2/0", rob_tail, rob_full); end
    if (cid_q.size() == 34) begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (cid_q[30+k] !== exp_id[k] || cval_q[30+k] !== 32'(30+k)) begin
          tests_failed++;
          $display("FAIL wrap_seq[%0d]: got id=%0d val=%0d want id=%0d val=%0d", k, cid_q[30+k], cval_q[30+k], exp_id[k], 30+k);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_issue(TypeRd, 5'd2, 1'b1, 32'hAB, 32'h0);
    tick();
    drive_issue(TypeRd, 5'd3, 1'b1, 32'hCD, 32'h0);
    tick();
    clear_inputs();
    tests_run++; if (commit_valid !== 1'b1 || commit_value !== 32'hAB) begin tests_failed++; $display("FAIL pre_reset_commit: got %0h/%0h want 1/ab", commit_valid, commit_value); end
    #2;
    rst_in = 1'b1;
    #1;
    tests_run++; if (commit_valid !== 1'b0 || commit_value !== 32'h0 || commit_rd !== 5'd0 || commit_id !== 5'd0)
      begin tests_failed++; $display("FAIL async_reset_commit: got v=%0h val=%0h rd=%0d id=%0d want 0", commit_valid, commit_value, commit_rd, commit_id); end
    tests_run++; if (rob_tail !== 5'd0 || rob_full !== 1'b0 || flush !== 1'b0 || st_commit !== 1'b0)
      begin tests_failed++; $display("FAIL async_reset_state: got tail=%0d full=%0h f=%0h st=%0h want 0", rob_tail, rob_full, flush, st_commit); end
    tick();
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_commit[%0d]: got %0h want 0", i, commit_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    qry_id1 = '0; qry_id2 = '0;
    clear_inputs();
    test_reset();
    test_commit_rd();
    test_full();
    test_flush();
    test_store_jump();
    test_wb_priority();
    test_back_to_back_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
